prb_req_queue: RTL

- Sits between the OX RX TileLink channel-B decoder and the probe state machine inside the coherent manager.
- Buffers incoming Probe messages (size, source, address) in a small FIFO.
- Presents one Probe at a time on the coherent manager's probe handshake (probe_req event, probe_req_ack pulse, probe_req_done pulse) and pops the entry on completion.
- A watchdog recovers the queue from a lost ack or done.

---
 rtl/prb_req_queue_pkg.sv | 26 ++
 rtl/prb_req_queue_if.sv | 49 ++++
 rtl/prb_req_queue_fifo.sv | 71 +++++++
 rtl/prb_req_queue.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/prb_req_queue_pkg.sv
// Shared coherent-manager types for the probe request queue: FSM states,
// probe entry layout and cache-line geometry.
package ox_coh_pkg;

  localparam int CACHE_LINE_LSB = 6;
  localparam int PRB_SRC_W      = 26;
  localparam int PRB_ADDR_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } prb_state_e;

  typedef struct packed {
    logic [3:0]            size;
    logic [PRB_SRC_W-1:0]  source;
    logic [PRB_ADDR_W-1:0] address;
  } prb_entry_t;

  // True when two addresses fall in the same 64-byte line.
  function automatic logic same_line(input logic [63:0] a, input logic [63:0] b);
    return a[63:CACHE_LINE_LSB] == b[63:CACHE_LINE_LSB];
  endfunction

endpackage

// File: rtl/prb_req_queue_if.sv
// Probe queue bus: RX decoder push side plus the coherent-manager probe handshake.
// dup_drop exists only when PRB_DUP_FILTER_EN is defined.
interface prb_req_queue_if #(
  parameter int DEPTH  = 4,
  parameter int SRC_W  = 26,
  parameter int ADDR_W = 64
);
  import ox_coh_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              rx_prb_valid;
  logic              rx_prb_ready;
  logic [3:0]        rx_prb_size;
  logic [SRC_W-1:0]  rx_prb_source;
  logic [ADDR_W-1:0] rx_prb_address;
  logic              probe_req;
  logic              probe_req_ack;
  logic              probe_req_done;
  logic [3:0]        b_size;
  logic [SRC_W-1:0]  b_source;
  logic [ADDR_W-1:0] b_address;
  logic [CNT_W-1:0]  q_count;
  logic              tmo_err;
`ifdef PRB_DUP_FILTER_EN
  logic              dup_drop;
`endif

  modport slave (
    input  rx_prb_valid, rx_prb_size, rx_prb_source, rx_prb_address,
    input  probe_req_ack, probe_req_done,
    output rx_prb_ready, probe_req, b_size, b_source, b_address, q_count,
`ifdef PRB_DUP_FILTER_EN
    output dup_drop,
`endif
    output tmo_err
  );

  modport master (
    output rx_prb_valid, rx_prb_size, rx_prb_source, rx_prb_address,
    output probe_req_ack, probe_req_done,
    input  rx_prb_ready, probe_req, b_size, b_source, b_address, q_count,
`ifdef PRB_DUP_FILTER_EN
    input  dup_drop,
`endif
    input  tmo_err
  );

endinterface

// File: rtl/prb_req_queue_fifo.sv
// DEPTH-entry synchronous FIFO with wrap-bit pointers and a registered count.
// With PRB_DUP_FILTER_EN the raw slots and their valid mask are exposed.
module prb_fifo
  import ox_coh_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
`ifdef PRB_DUP_FILTER_EN
  output logic [DEPTH-1:0][W-1:0]  slots,
  output logic [DEPTH-1:0]         slot_vld,
`endif
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][W-1:0] mem_r;
  logic [PTR_W:0]          wr_ptr_r;
  logic [PTR_W:0]          rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_r[rd_ptr_r[PTR_W-1:0]];
  assign count   = count_r;

  // pointer and occupancy update
  always_ff @(posedge clk) begin
    if (reset_) begin
      wr_ptr_r <= {CNT_W{1'b0}};
      rd_ptr_r <= {CNT_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) wr_ptr_r <= wr_ptr_r + CNT_W'(1);
      if (do_pop)  rd_ptr_r <= rd_ptr_r + CNT_W'(1);
      count_r <= count_r + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // storage is write-only-when-pushed; stale slots are masked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
  end

`ifdef PRB_DUP_FILTER_EN
  assign slots = mem_r;

  // a slot is live when its distance from the read pointer is below the count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_vld[i] = (CNT_W'(PTR_W'(i) - rd_ptr_r[PTR_W-1:0]) < count_r);
    end
  end
`endif

endmodule

// File: rtl/prb_req_queue.sv
// Probe request queue: buffers channel-B Probes and presents them one at a time
// to the coherent manager with a watchdog. Optional feature macro: PRB_DUP_FILTER_EN.
module prb_req_queue
  import ox_coh_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SRC_W   = 26,
  parameter int ADDR_W  = 64,
  parameter int TMO_CYC = 1023
) (
  input  logic               clk,
  input  logic               reset_,
  prb_req_queue_if.slave     bus
);

  localparam int ENT_W = 4 + SRC_W + ADDR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WD_W  = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  prb_state_e       state_r;
  prb_state_e       state_nxt;
  logic [WD_W-1:0]  wdog_r;
  logic [WD_W-1:0]  wdog_nxt;
  logic [WD_W-1:0]  wdog_inc;
  logic             req_r;
  logic             req_nxt;
  logic             tmo_r;
  logic             tmo_nxt;
  logic             ready_r;
  logic [ENT_W-1:0] b_r;
  logic             load_b;
  logic             push;
  logic             wr_en;
  logic             pop;
  logic             tmo_hit;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] wdata;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             full;
  logic             empty;

  assign push  = bus.rx_prb_valid & ready_r & ~full;
  assign wdata = {bus.rx_prb_size, bus.rx_prb_source, bus.rx_prb_address};

`ifdef PRB_DUP_FILTER_EN
  logic [DEPTH-1:0][ENT_W-1:0] slots;
  logic [DEPTH-1:0]            slot_vld;
  logic                        dup_hit;
  logic                        dup_r;

  // line match against every live entry, including the in-flight head
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dup_hit = dup_hit | (slot_vld[i] &
                same_line(64'(slots[i][ADDR_W-1:0]), 64'(bus.rx_prb_address)));
    end
  end

  assign wr_en        = push & ~dup_hit;
  assign bus.dup_drop = dup_r;
`else
  assign wr_en = push;
`endif

  prb_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk      (clk),
    .reset_   (reset_),
    .push     (wr_en),
    .wdata    (wdata),
    .pop      (pop),
`ifdef PRB_DUP_FILTER_EN
    .slots    (slots),
    .slot_vld (slot_vld),
`endif
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // expiry fires on the edge the counter would reach TMO_CYC
  assign tmo_hit   = (TMO_CYC != 0) && (state_r != ST_IDLE) &&
                     (wdog_r == WD_W'(TMO_CYC - 1));
  assign wdog_inc  = (wdog_r == {WD_W{1'b1}}) ? wdog_r : wdog_r + WD_W'(1);
  assign count_nxt = count + CNT_W'(wr_en) - CNT_W'(pop);

  // request FSM and watchdog next-state
  always_comb begin
    state_nxt = state_r;
    req_nxt   = req_r;
    wdog_nxt  = wdog_r;
    tmo_nxt   = 1'b0;
    pop       = 1'b0;
    load_b    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty) begin
          load_b    = 1'b1;
          req_nxt   = 1'b1;
          wdog_nxt  = WD_W'(0);
          state_nxt = ST_REQ;
        end else begin
          req_nxt   = 1'b0;
        end
      end
      ST_REQ: begin
        if (tmo_hit) begin
          tmo_nxt   = 1'b1;
          pop       = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else if (bus.probe_req_ack && bus.probe_req_done) begin
          pop       = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else if (bus.probe_req_ack) begin
          req_nxt   = 1'b0;
          wdog_nxt  = WD_W'(0);
          state_nxt = ST_ACTIVE;
        end else begin
          wdog_nxt  = wdog_inc;
        end
      end
      ST_ACTIVE: begin
        if (tmo_hit) begin
          tmo_nxt   = 1'b1;
          pop       = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else if (bus.probe_req_done) begin
          pop       = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          wdog_nxt  = wdog_inc;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        wdog_nxt  = WD_W'(0);
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // state, outputs and head snapshot
  always_ff @(posedge clk) begin
    if (reset_) begin
      state_r <= ST_IDLE;
      wdog_r  <= WD_W'(0);
      req_r   <= 1'b0;
      tmo_r   <= 1'b0;
      ready_r <= 1'b1;
      b_r     <= {ENT_W{1'b0}};
`ifdef PRB_DUP_FILTER_EN
      dup_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      wdog_r  <= wdog_nxt;
      req_r   <= req_nxt;
      tmo_r   <= tmo_nxt;
      ready_r <= (count_nxt != CNT_W'(DEPTH));
      if (load_b) b_r <= head;
`ifdef PRB_DUP_FILTER_EN
      dup_r   <= push & dup_hit;
`endif
    end
  end

  assign bus.rx_prb_ready = ready_r;
  assign bus.probe_req    = req_r;
  assign bus.tmo_err      = tmo_r;
  assign bus.q_count      = count;
  assign bus.b_size       = b_r[ENT_W-1 -: 4];
  assign bus.b_source     = b_r[ADDR_W +: SRC_W];
  assign bus.b_address    = b_r[ADDR_W-1:0];

endmodule
